// File: rtl/mux_pkg.sv
// Shared definitions for the four-source mux select arbiter: state encoding,
// channel count and the default grant hold limit.
package mux_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NUM_CH       = 4;
  localparam int HOLD_MAX_DEF = 8;

endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotating-priority pick: first asserted request at or above
// i_ptr, wrapping modulo 4.
module rr_pick_4
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] i_req,
  input  logic [1:0]        i_ptr,
  output logic [1:0]        o_idx,
  output logic              o_found
);

  logic [1:0] w_cand;

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_cand  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_cand = i_ptr + 2'(k);
      if (i_req[w_cand]) begin
        o_idx   = w_cand;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arb_4.sv
// Four-source round-robin arbiter driving a registered mux select and one-hot
// grant. Optional forced release after HOLD_MAX cycles with HOLD_TIMEOUT_EN.
module mux_sel_arb_4
  import mux_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req_0,
  input  logic req_1,
  input  logic req_2,
  input  logic req_3,
  input  logic done,
  output logic s_0,
  output logic s_1,
  output logic gnt_0,
  output logic gnt_1,
  output logic gnt_2,
  output logic gnt_3,
  output logic gnt_valid
);

  if (HOLD_MAX < 1) begin : g_bad_hold
    $error("HOLD_MAX must be at least 1");
  end

  logic [NUM_CH-1:0] w_req;
  state_t            r_state, w_state_nxt;
  logic [1:0]        r_ptr, w_ptr_nxt;
  logic [1:0]        r_sel, w_sel_nxt;
  logic [NUM_CH-1:0] r_gnt, w_gnt_nxt;
  logic              r_gnt_valid;
  logic [1:0]        w_pick_idx;
  logic              w_found;
  logic              w_release;

  assign w_req = {req_3, req_2, req_1, req_0};

`ifdef HOLD_TIMEOUT_EN
  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_timeout;

  // r_cnt holds (GRANT cycles elapsed - 1), so this flags the HOLD_MAX-th cycle.
  assign w_timeout = (r_cnt == CNT_W'(HOLD_MAX - 1));
`endif

  rr_pick_4 u_pick (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_found)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_gnt_nxt   = r_gnt;
    w_release   = 1'b0;
`ifdef HOLD_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_sel_nxt   = w_pick_idx;
          w_gnt_nxt   = NUM_CH'(1) << w_pick_idx;
`ifdef HOLD_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end
      end
      GRANT: begin
        // Select and grant are frozen; only a release cause ends the grant.
        w_release = done | ~w_req[r_sel];
`ifdef HOLD_TIMEOUT_EN
        w_release = w_release | w_timeout;
        w_cnt_nxt = r_cnt + CNT_W'(1);
`endif
        if (w_release) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_ptr_nxt   = r_sel + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_sel       <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_sel       <= w_sel_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= |w_gnt_nxt;
`ifdef HOLD_TIMEOUT_EN
      r_cnt       <= w_cnt_nxt;
`endif
    end
  end

  assign s_0       = r_sel[0];
  assign s_1       = r_sel[1];
  assign gnt_0     = r_gnt[0];
  assign gnt_1     = r_gnt[1];
  assign gnt_2     = r_gnt[2];
  assign gnt_3     = r_gnt[3];
  assign gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_mux_sel_arb_4.sv
// Directed bench for mux_sel_arb_4; outputs packed as
// {gnt_valid, gnt_3..gnt_0, s_1, s_0}. Timeout checks follow HOLD_TIMEOUT_EN.
module tb_mux_sel_arb_4;

  logic clk, rst, req_0, req_1, req_2, req_3, done;
  logic s_0, s_1, gnt_0, gnt_1, gnt_2, gnt_3, gnt_valid;
  logic [6:0] w_out;
  int n_vec = 0;
  int n_err = 0;

  mux_sel_arb_4 dut (
    .clk       (clk),
    .rst       (rst),
    .req_0     (req_0),
    .req_1     (req_1),
    .req_2     (req_2),
    .req_3     (req_3),
    .done      (done),
    .s_0       (s_0),
    .s_1       (s_1),
    .gnt_0     (gnt_0),
    .gnt_1     (gnt_1),
    .gnt_2     (gnt_2),
    .gnt_3     (gnt_3),
    .gnt_valid (gnt_valid)
  );

  assign w_out = {gnt_valid, gnt_3, gnt_2, gnt_1, gnt_0, s_1, s_0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_ptr(input string tag, input logic [1:0] exp);
    chk(tag, {5'b0, dut.r_ptr}, {5'b0, exp});
  endtask

  initial begin
    logic [6:0] e;
    rst = 1'b1; done = 1'b0;
    {req_3, req_2, req_1, req_0} = 4'b0000;

    step();
    chk("reset_out", w_out, 7'b0_0000_00);
    chk_ptr("reset_ptr", 2'd0);
    rst = 1'b0;

    // Idle with no request; done in IDLE is ignored
    step();
    chk("idle_hold", w_out, 7'b0_0000_00);
    done = 1'b1;
    step();
    chk("idle_done_ignored", w_out, 7'b0_0000_00);
    done = 1'b0;

    // Single request on source 2, release by done
    req_2 = 1'b1;
    step();
    chk("g2_grant", w_out, 7'b1_0100_10);
    step();
    chk("g2_hold", w_out, 7'b1_0100_10);
    done = 1'b1;
    step();
    chk("g2_release", w_out, 7'b0_0000_10);
    chk_ptr("g2_ptr", 2'd3);
    done = 1'b0; req_2 = 1'b0;
    step();
    chk("g2_sel_held", w_out, 7'b0_0000_10);

    // All four requesting: order 0,1,2,3,0 with a bubble between grants
    rst = 1'b1;
    step();
    rst = 1'b0;
    {req_3, req_2, req_1, req_0} = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      done = 1'b0;
      step();
      e = {1'b1, 4'(1 << (i % 4)), 2'(i % 4)};
      chk("rr_grant", w_out, e);
      done = 1'b1;
      step();
      chk("rr_bubble", w_out, {5'b0, 2'(i % 4)});
    end
    chk_ptr("rr_ptr", 2'd1);
    done = 1'b0;
    {req_3, req_2, req_1, req_0} = 4'b0000;

    // Grant on 1 stays put while req_3 arrives; 3 wins next
    req_1 = 1'b1;
    step();
    chk("g1_grant", w_out, 7'b1_0010_01);
    req_3 = 1'b1;
    step();
    chk("g1_hold_a", w_out, 7'b1_0010_01);
    step();
    chk("g1_hold_b", w_out, 7'b1_0010_01);
    done = 1'b1; req_1 = 1'b0;
    step();
    chk("g1_release", w_out, 7'b0_0000_01);
    chk_ptr("g1_ptr", 2'd2);
    done = 1'b0;
    step();
    chk("g3_grant", w_out, 7'b1_1000_11);

    // Reset mid-grant on 3; first grant after reset favours 0
    rst = 1'b1;
    step();
    chk("rst_mid_out", w_out, 7'b0_0000_00);
    chk_ptr("rst_mid_ptr", 2'd0);
    rst = 1'b0; req_0 = 1'b1;
    step();
    chk("post_rst_g0", w_out, 7'b1_0001_00);

    // Request drop releases the grant without done
    req_0 = 1'b0;
    step();
    chk("drop_release", w_out, 7'b0_0000_00);
    chk_ptr("drop_ptr", 2'd1);
    step();
    chk("drop_next_g3", w_out, 7'b1_1000_11);
    req_3 = 1'b0;
    step();
    chk("g3_drop", w_out, 7'b0_0000_11);

    // Hold limit behaviour with req_1 held and done low
    rst = 1'b1;
    step();
    rst = 1'b0; req_1 = 1'b1;
    step();
    chk("hold_grant", w_out, 7'b1_0010_01);
`ifdef HOLD_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      step();
      chk("to_held", w_out, 7'b1_0010_01);
    end
    step();
    chk("to_release", w_out, 7'b0_0000_01);
    step();
    chk("to_regrant", w_out, 7'b1_0010_01);
    for (int k = 1; k < 7; k++) begin
      step();
      chk("to_held2", w_out, 7'b1_0010_01);
    end
    // Eighth cycle: timeout and done coincide
    step();
    chk("to_held2_last", w_out, 7'b1_0010_01);
    done = 1'b1;
    step();
    chk("to_done_release", w_out, 7'b0_0000_01);
    done = 1'b0;
    step();
    chk("to_done_regrant", w_out, 7'b1_0010_01);
`else
    for (int k = 1; k < 12; k++) begin
      step();
      chk("no_to_held", w_out, 7'b1_0010_01);
    end
    done = 1'b1;
    step();
    chk("no_to_release", w_out, 7'b0_0000_01);
    done = 1'b0;
`endif
    req_1 = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
